// File: rtl/reg_share_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_share_pkg
// Description : Shared types and the round-robin search helper for
//               reg_share_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_share_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Returns the first set bit of req scanning ptr+1, ptr+2, ... modulo n,
    // wrapping back to ptr itself last. With no bit set, ptr is returned.
    function automatic logic [31:0] rr_pick(input logic [31:0] req,
                                            input logic [31:0] n,
                                            input logic [31:0] ptr);
        logic [31:0] idx;
        logic [31:0] j;
        logic        hit;
        idx = ptr;
        hit = 1'b0;
        for (int unsigned i = 1; i <= 32; i++) begin
            j = ptr + i;
            if (j >= n) begin
                j = j - n;
            end
            if (!hit && (i <= n) && req[j[4:0]]) begin
                idx = j;
                hit = 1'b1;
            end
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_priority_pick.sv
`default_nettype none
// ============================================================================
// Module      : rr_priority_pick
// Description : Combinational N-way round-robin search starting at ptr+1.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_priority_pick
    import reg_share_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          found,
    output logic [IW-1:0] idx
);

    assign found = |req;
    assign idx   = IW'(rr_pick(32'(req), 32'(N), 32'(ptr)));

endmodule
`default_nettype wire

// File: rtl/reg_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : reg_share_arbiter
// Description : Round-robin, burst-limited sharing of one enabled register
//               among N requesters. Optional macro ARB_LOCK_EN adds a lock
//               input that suspends burst-limit preemption.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_share_arbiter
    import reg_share_pkg::*;
#(
    parameter int N         = 4,
    parameter int W         = 1,
    parameter int MAX_BURST = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic [N*W-1:0]       req_d,
`ifdef ARB_LOCK_EN
    input  logic                 lock,
`endif
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] owner,
    output logic                 busy,
    output logic                 en_out,
    output logic [W-1:0]         d_out
);

    localparam int IW = $clog2(N);
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] C_MAX = CW'(MAX_BURST);
    localparam logic [CW-1:0] C_ONE = CW'(1);

    state_t        state_q, state_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [IW-1:0] rr_ptr_q, rr_ptr_d;
    logic          en_q, en_d;
    logic [W-1:0]  dout_q, dout_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [IW-1:0] search_ptr;
    logic          pick_found;
    logic [IW-1:0] pick_idx;
    logic          lock_w;

`ifdef ARB_LOCK_EN
    assign lock_w = lock;
`else
    assign lock_w = 1'b0;
`endif

    // While busy the search starts after the current owner, so a request
    // from the owner itself is only chosen when nobody else is asking.
    assign search_ptr = (state_q == ST_BUSY) ? owner_q : rr_ptr_q;

    rr_priority_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .req   (req),
        .ptr   (search_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        en_d     = 1'b0;
        dout_d   = dout_q;
        cnt_d    = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    state_d = ST_BUSY;
                    gnt_d   = {{(N-1){1'b0}}, 1'b1} << pick_idx;
                    owner_d = pick_idx;
                    en_d    = 1'b1;
                    dout_d  = req_d[pick_idx*W +: W];
                    cnt_d   = C_ONE;
                end else begin
                    gnt_d = '0;
                end
            end
            ST_BUSY: begin
                if (req[owner_q] && ((cnt_q < C_MAX) || lock_w)) begin
                    en_d   = 1'b1;
                    dout_d = req_d[owner_q*W +: W];
                    cnt_d  = (cnt_q == C_MAX) ? C_MAX : cnt_q + C_ONE;
                end else if (pick_found) begin
                    // Covers both burst-limit rotation and early handover.
                    gnt_d   = {{(N-1){1'b0}}, 1'b1} << pick_idx;
                    owner_d = pick_idx;
                    en_d    = 1'b1;
                    dout_d  = req_d[pick_idx*W +: W];
                    cnt_d   = C_ONE;
                end else begin
                    state_d  = ST_IDLE;
                    gnt_d    = '0;
                    rr_ptr_d = owner_q;
                    cnt_d    = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            gnt_q    <= '0;
            owner_q  <= '0;
            rr_ptr_q <= IW'(N - 1);
            en_q     <= 1'b0;
            dout_q   <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
            en_q     <= en_d;
            dout_q   <= dout_d;
            cnt_q    <= cnt_d;
        end
    end

    assign gnt    = gnt_q;
    assign owner  = owner_q;
    assign busy   = (state_q == ST_BUSY);
    assign en_out = en_q;
    assign d_out  = dout_q;

endmodule
`default_nettype wire

// File: tb/tb_reg_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_share_arbiter
// Description : Directed and random self-checking bench for reg_share_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_share_arbiter;

    localparam int N  = 4;
    localparam int W  = 1;
    localparam int MB = 3;

    logic         clk;
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] req_d;
    logic         lock;
    logic [N-1:0] gnt;
    logic [1:0]   owner;
    logic         busy;
    logic         en_out;
    logic [W-1:0] d_out;
    logic         q;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference state
    bit       m_busy;
    int       m_owner;
    int       m_cnt;
    int       m_ptr;
    bit       m_en;
    bit       m_d;
    bit       m_q;
    bit [3:0] m_gnt;

    reg_share_arbiter #(.N(N), .W(W), .MAX_BURST(MB)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .req_d  (req_d),
`ifdef ARB_LOCK_EN
        .lock   (lock),
`endif
        .gnt    (gnt),
        .owner  (owner),
        .busy   (busy),
        .en_out (en_out),
        .d_out  (d_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // The shared register being driven by the arbiter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) q <= 1'b0;
        else if (en_out) q <= d_out;
    end

    function automatic int first_after(input bit [3:0] r, input int start);
        for (int k = 1; k <= N; k++) begin
            if (r[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_owner = 0; m_cnt = 0; m_ptr = N - 1;
        m_en = 0; m_d = 0; m_q = 0; m_gnt = 4'b0000;
    endtask

    task automatic model_grant(input int w, input bit [3:0] rd);
        m_busy = 1; m_owner = w; m_gnt = 4'b0001 << w;
        m_en = 1; m_d = rd[w]; m_cnt = 1;
    endtask

    task automatic model_step(input bit [3:0] r, input bit [3:0] rd, input bit lk);
        int w;
        bit [3:0] others;
        if (m_en) m_q = m_d;
        m_en = 0;
`ifndef ARB_LOCK_EN
        lk = 0;
`endif
        if (!m_busy) begin
            w = first_after(r, m_ptr);
            if (w >= 0) model_grant(w, rd);
        end else if (r[m_owner] && m_cnt < MB) begin
            m_cnt++; m_en = 1; m_d = rd[m_owner];
        end else if (r[m_owner] && lk) begin
            m_cnt = MB; m_en = 1; m_d = rd[m_owner];
        end else if (r[m_owner]) begin
            others = r & ~(4'b0001 << m_owner);
            if (others != 0) model_grant(first_after(others, m_owner), rd);
            else model_grant(m_owner, rd);
        end else begin
            w = first_after(r, m_owner);
            if (w >= 0) begin
                model_grant(w, rd);
            end else begin
                m_busy = 0; m_gnt = 0; m_ptr = m_owner; m_cnt = 0;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".gnt"},    32'(gnt),    32'(m_gnt));
        check({tag, ".busy"},   32'(busy),   32'(m_busy));
        check({tag, ".en_out"}, 32'(en_out), 32'(m_en));
        check({tag, ".d_out"},  32'(d_out),  32'(m_d));
        check({tag, ".q"},      32'(q),      32'(m_q));
        if (m_busy) check({tag, ".owner"}, 32'(owner), 32'(m_owner));
    endtask

    task automatic cycle(input string tag, input bit [3:0] r, input bit [3:0] rd, input bit lk);
        req = r; req_d = rd; lock = lk;
        @(posedge clk);
        if (rst) model_reset();
        else model_step(r, rd, lk);
        #1;
        check_all(tag);
    endtask

    initial begin
        int exp_own [7];
        exp_own = '{0, 0, 0, 1, 1, 1, 0};
        rst = 1'b1; req = '0; req_d = '0; lock = 1'b0;
        model_reset();

        // Reset held with everyone requesting
        for (int i = 0; i < 3; i++) cycle("reset", 4'b1111, 4'b1111, 1'b0);
        check("reset.owner", 32'(owner), 32'd0);
        rst = 1'b0;
        cycle("first", 4'b1111, 4'b0001, 1'b0);
        check("first.gnt_const", 32'(gnt), 32'h1);
        check("first.owner_const", 32'(owner), 32'd0);
        cycle("idle0", 4'b0000, 4'b0000, 1'b0);

        // Single requester keeps the grant past the burst limit
        for (int i = 0; i < 6; i++) begin
            cycle("single", 4'b0100, 4'b0100, 1'b0);
            check("single.gnt_const", 32'(gnt), 32'h4);
            check("single.d_const", 32'(d_out), 32'h1);
        end
        cycle("single_drop", 4'b0000, 4'b0000, 1'b0);
        check("single_drop.busy_const", 32'(busy), 32'd0);
        check("single_drop.q_const", 32'(q), 32'd1);

        // Burst rotation between 0 and 1
        for (int i = 0; i < 7; i++) begin
            cycle("burst", 4'b0011, 4'(i), 1'b0);
            check("burst.owner_seq", 32'(owner), 32'(exp_own[i]));
            check("burst.en_const", 32'(en_out), 32'd1);
        end

        // Early release: 0 hands to 1, then 1 hands to 3 with no gap
        cycle("early_a", 4'b1010, 4'b0010, 1'b0);
        check("early_a.gnt_const", 32'(gnt), 32'h2);
        cycle("early_b", 4'b1000, 4'b1000, 1'b0);
        check("early_b.gnt_const", 32'(gnt), 32'h8);
        check("early_b.en_const", 32'(en_out), 32'd1);

        // Asynchronous reset in owner 2's second cycle
        cycle("idle1", 4'b0000, 4'b0000, 1'b0);
        cycle("mid_a", 4'b0100, 4'b0100, 1'b0);
        cycle("mid_b", 4'b0100, 4'b0100, 1'b0);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_all("mid_async");
        cycle("mid_hold", 4'b0101, 4'b0101, 1'b0);
        rst = 1'b0;
        cycle("mid_after", 4'b0101, 4'b0001, 1'b0);
        check("mid_after.owner_const", 32'(owner), 32'd0);

`ifdef ARB_LOCK_EN
        for (int i = 0; i < 8; i++) begin
            cycle("lock", 4'b0011, 4'b0011, 1'b1);
            check("lock.owner_const", 32'(owner), 32'd0);
        end
        cycle("unlock", 4'b0011, 4'b0011, 1'b0);
        check("unlock.owner_const", 32'(owner), 32'd1);
`endif

        // Random traffic, biased toward sustained requests
        for (int i = 0; i < 400; i++) begin
            bit [3:0] r;
            r = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) r = req;
            cycle("rand", r, 4'($urandom), 1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
